// File: rtl/uart_sender_arbiter.sv
// uart_sender_arbiter: locks the shared UART element sender to one requester at a time
//
// Round-robin arbiter with per-owner grant locking. The owner keeps the sender
// until it drops req, so a whole matrix printout is never interleaved.
// Optional idle-owner watchdog: define UART_SENDER_ARB_WDOG_EN.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req[N_REQ]          level request per requester
//   grant[N_REQ]        registered one-hot ownership
//   cli_*               per-requester sender controls (data slice i = [i*DATA_W +: DATA_W])
//   cli_done[N_REQ]     snd_done routed to the owner only
//   snd_*               muxed controls to the sender; snd_done comes back from it
//   busy                arbiter not idle
//   owner               index of current or last owner
//   proto_err           sticky: owner started while a send was in flight
//   wdog_revoke         1-cycle pulse when the watchdog revokes a grant
module uart_sender_arbiter #(
    parameter int N_REQ       = 3,
    parameter int DATA_W      = 8,
    parameter int WDOG_CYCLES = 100_000_000,
    localparam int IDX_W      = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    output logic [N_REQ-1:0]        grant,
    input  logic [N_REQ*DATA_W-1:0] cli_data,
    input  logic [N_REQ-1:0]        cli_start,
    input  logic [N_REQ-1:0]        cli_is_last_col,
    input  logic [N_REQ-1:0]        cli_newline_only,
    input  logic [N_REQ-1:0]        cli_id,
    output logic [N_REQ-1:0]        cli_done,
    output logic [DATA_W-1:0]       snd_data,
    output logic                    snd_start,
    output logic                    snd_is_last_col,
    output logic                    snd_newline_only,
    output logic                    snd_id,
    input  logic                    snd_done,
    output logic                    busy,
    output logic [IDX_W-1:0]        owner,
    output logic                    proto_err,
    output logic                    wdog_revoke
);
    if (N_REQ < 2 || N_REQ > 8 || WDOG_CYCLES < 1) begin : g_param_err
        $error("uart_sender_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, OWNED, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d, elig;
    logic [IDX_W-1:0]   owner_q, owner_d, rr_ptr_q, rr_ptr_d, win;
    logic               in_flight_q, in_flight_d, proto_err_q, proto_err_d;
    logic               found, active, own_req, own_start, fwd_start, wdog_fire;
    int                 j;

    assign active    = state_q != IDLE;
    assign own_req   = req[owner_q];
    assign own_start = cli_start[owner_q];
    assign fwd_start = (state_q == OWNED) & own_start & ~in_flight_q;

`ifdef UART_SENDER_ARB_WDOG_EN
    localparam int CNT_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

    logic [CNT_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic [N_REQ-1:0] mask_q, mask_d;
    logic             wdog_revoke_q, idle_own;

    // Owner holds the sender but is doing nothing with it.
    assign idle_own  = (state_q == OWNED) & own_req & ~in_flight_q & ~fwd_start;
    assign wdog_fire = idle_own & (wdog_cnt_q == CNT_W'(WDOG_CYCLES - 1));

    // A revoked requester stays masked until its req is seen low; grant_q is
    // the owner's one-hot while OWNED.
    always_comb begin
        wdog_cnt_d = (idle_own & ~wdog_fire) ? wdog_cnt_q + 1'b1 : '0;
        mask_d     = (mask_q & req) | (wdog_fire ? grant_q : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt_q    <= '0;
            mask_q        <= '0;
            wdog_revoke_q <= 1'b0;
        end else begin
            wdog_cnt_q    <= wdog_cnt_d;
            mask_q        <= mask_d;
            wdog_revoke_q <= wdog_fire;
        end
    end

    assign elig        = req & ~mask_q;
    assign wdog_revoke = wdog_revoke_q;
`else
    assign wdog_fire   = 1'b0;
    assign elig        = req;
    assign wdog_revoke = 1'b0;
`endif

    // First eligible requester searching upward from rr_ptr with wrap-around.
    always_comb begin
        win   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(rr_ptr_q) + i - ((int'(rr_ptr_q) + i >= N_REQ) ? N_REQ : 0);
            if (!found && elig[IDX_W'(j)]) begin
                win   = IDX_W'(j);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        // A start and a done in the same cycle leave the send in flight.
        in_flight_d = active & (fwd_start | (in_flight_q & ~snd_done));
        proto_err_d = proto_err_q | (active & own_start & in_flight_q);
        case (state_q)
            IDLE: if (found) begin
                state_d  = OWNED;
                grant_d  = N_REQ'(1) << win;
                owner_d  = win;
                rr_ptr_d = (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
            end
            OWNED: if (!own_req && in_flight_d) begin
                state_d = DRAIN;
            end else if (!own_req || wdog_fire) begin
                state_d = IDLE;
                grant_d = '0;
            end
            DRAIN: if (snd_done) begin
                state_d = IDLE;
                grant_d = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            in_flight_q <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            in_flight_q <= in_flight_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_comb begin
        snd_data         = '0;
        snd_is_last_col  = 1'b0;
        snd_newline_only = 1'b0;
        snd_id           = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (active && owner_q == IDX_W'(i)) begin
                snd_data         = cli_data[i*DATA_W +: DATA_W];
                snd_is_last_col  = cli_is_last_col[i];
                snd_newline_only = cli_newline_only[i];
                snd_id           = cli_id[i];
            end
        end
    end

    assign snd_start = fwd_start;
    assign cli_done  = (active & snd_done) ? grant_q : '0;
    assign grant     = grant_q;
    assign busy      = active;
    assign owner     = owner_q;
    assign proto_err = proto_err_q;
endmodule
